// File: rtl/multicycle_ctrl.sv
// Multicycle processor controller.
// Every instruction walks F0, F1, DEC, EX, M0, M1, WB, PCU (8 cycles) regardless
// of class; the class only decides which memory/writeback strobes fire.
// run/halt_req act as a simple start/stop pair: run is sampled in IDLE to start,
// and both run and halt_req are sampled in PCU to decide whether to fetch again.
// All strobes are flops loaded from the next-state value, so each one is a pure
// function of the state register with no path from any input to any output.
module multicycle_ctrl #(
    parameter int MemSize = 10,
    parameter int CntSize = 128
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               run,
    input  logic               halt_req,
    input  logic [1:0]         inst_class,
    input  logic               br_taken,
    input  logic [MemSize-1:0] br_target,
    output logic               IM_enable,
    output logic               IM_read,
    output logic               IM_write,
    output logic               DM_enable,
    output logic               DM_read,
    output logic               DM_write,
    output logic               ir_load,
    output logic               alu_en,
    output logic               mdr_load,
    output logic               reg_write,
    output logic [MemSize-1:0] PC,
    output logic [CntSize-1:0] cycle_cnt,
    output logic [31:0]        inst_cnt,
    output logic               busy,
    output logic [3:0]         dbg_state
);

    typedef enum logic [3:0] {
        S_IDLE = 4'd0,
        S_F0   = 4'd1,
        S_F1   = 4'd2,
        S_DEC  = 4'd3,
        S_EX   = 4'd4,
        S_M0   = 4'd5,
        S_M1   = 4'd6,
        S_WB   = 4'd7,
        S_PCU  = 4'd8
    } state_t;

    localparam logic [1:0] CLS_ALU   = 2'b00;
    localparam logic [1:0] CLS_LOAD  = 2'b01;
    localparam logic [1:0] CLS_STORE = 2'b10;

    state_t             state;
    state_t             state_nxt;
    logic [1:0]         cls;
    logic               br_taken_q;
    logic [MemSize-1:0] br_target_q;

    logic fetch_nxt;
    logic mem_nxt;
    logic is_load;
    logic is_store;

    // The instruction memory is never written by this controller.
    assign IM_write  = 1'b0;
    assign dbg_state = state;

    assign is_load  = (cls == CLS_LOAD);
    assign is_store = (cls == CLS_STORE);

    // Next-state sequencing: fixed 8-step walk, with start/stop decisions only in IDLE and PCU.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  state_nxt = run ? S_F0 : S_IDLE;
            S_F0:    state_nxt = S_F1;
            S_F1:    state_nxt = S_DEC;
            S_DEC:   state_nxt = S_EX;
            S_EX:    state_nxt = S_M0;
            S_M0:    state_nxt = S_M1;
            S_M1:    state_nxt = S_WB;
            S_WB:    state_nxt = S_PCU;
            S_PCU:   state_nxt = (halt_req || !run) ? S_IDLE : S_F0;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Phase groupings of the upcoming state, used to load the strobe flops.
    always_comb begin
        fetch_nxt = (state_nxt == S_F0) || (state_nxt == S_F1);
        mem_nxt   = (state_nxt == S_M0) || (state_nxt == S_M1);
    end

    // State register, instruction-scoped latches, PC/counters and registered strobes.
    // cls is latched leaving DEC and is therefore stable before M0/M1/WB strobes are loaded.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            cls         <= 2'b00;
            br_taken_q  <= 1'b0;
            br_target_q <= '0;
            PC          <= '0;
            cycle_cnt   <= '0;
            inst_cnt    <= '0;
            IM_enable   <= 1'b0;
            IM_read     <= 1'b0;
            DM_enable   <= 1'b0;
            DM_read     <= 1'b0;
            DM_write    <= 1'b0;
            ir_load     <= 1'b0;
            alu_en      <= 1'b0;
            mdr_load    <= 1'b0;
            reg_write   <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state <= state_nxt;

            if (state != S_IDLE) begin
                cycle_cnt <= cycle_cnt + CntSize'(1);
            end

            if (state == S_DEC) begin
                cls <= inst_class;
            end

            if (state == S_EX) begin
                br_taken_q  <= br_taken;
                br_target_q <= br_target;
            end

            if (state == S_PCU) begin
                PC       <= br_taken_q ? br_target_q : PC + MemSize'(1);
                inst_cnt <= inst_cnt + 32'd1;
            end

            IM_enable <= fetch_nxt;
            IM_read   <= fetch_nxt;
            ir_load   <= (state_nxt == S_F1);
            alu_en    <= (state_nxt == S_EX);
            DM_enable <= mem_nxt && (is_load || is_store);
            DM_read   <= mem_nxt && is_load;
            DM_write  <= mem_nxt && is_store;
            mdr_load  <= (state_nxt == S_M1) && is_load;
            reg_write <= (state_nxt == S_WB) && ((cls == CLS_ALU) || is_load);
            busy      <= (state_nxt != S_IDLE);
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: a step-counter model of the instruction walk is
// compared against every output on each falling edge, and directed sequences
// pin the model with hand-computed PC / counter / strobe values.
module tb_multicycle_ctrl;

    logic         clk;
    logic         reset;
    logic         run;
    logic         halt_req;
    logic [1:0]   inst_class;
    logic         br_taken;
    logic [9:0]   br_target;
    logic         IM_enable, IM_read, IM_write;
    logic         DM_enable, DM_read, DM_write;
    logic         ir_load, alu_en, mdr_load, reg_write;
    logic [9:0]   PC;
    logic [127:0] cycle_cnt;
    logic [31:0]  inst_cnt;
    logic         busy;
    logic [3:0]   dbg_state;

    int n_checks = 0;
    int n_fail   = 0;
    bit check_en = 0;

    multicycle_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .run        (run),
        .halt_req   (halt_req),
        .inst_class (inst_class),
        .br_taken   (br_taken),
        .br_target  (br_target),
        .IM_enable  (IM_enable),
        .IM_read    (IM_read),
        .IM_write   (IM_write),
        .DM_enable  (DM_enable),
        .DM_read    (DM_read),
        .DM_write   (DM_write),
        .ir_load    (ir_load),
        .alu_en     (alu_en),
        .mdr_load   (mdr_load),
        .reg_write  (reg_write),
        .PC         (PC),
        .cycle_cnt  (cycle_cnt),
        .inst_cnt   (inst_cnt),
        .busy       (busy),
        .dbg_state  (dbg_state)
    );

    // Clock: 10 time-unit period, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: step -1 is idle, 0..7 are the eight steps of one instruction.
    int           m_step = -1;
    logic [1:0]   m_cls  = 2'b00;
    logic         m_bt   = 1'b0;
    logic [9:0]   m_btgt = 10'd0;
    logic [9:0]   m_pc   = 10'd0;
    logic [127:0] m_cyc  = 128'd0;
    logic [31:0]  m_inst = 32'd0;

    // Model advance on each rising edge; reset clears it immediately.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_step = -1;
            m_cls  = 2'b00;
            m_bt   = 1'b0;
            m_btgt = 10'd0;
            m_pc   = 10'd0;
            m_cyc  = 128'd0;
            m_inst = 32'd0;
        end else begin
            if (m_step >= 0) m_cyc = m_cyc + 128'd1;
            if (m_step < 0) begin
                m_step = run ? 0 : -1;
            end else if (m_step == 7) begin
                m_pc   = m_bt ? m_btgt : m_pc + 10'd1;
                m_inst = m_inst + 32'd1;
                m_step = (halt_req || !run) ? -1 : 0;
            end else begin
                if (m_step == 2) m_cls = inst_class;
                if (m_step == 3) begin
                    m_bt   = br_taken;
                    m_btgt = br_target;
                end
                m_step = m_step + 1;
            end
        end
    end

    // Per-cycle comparison of every output against the model, plus safety invariants.
    always @(negedge clk) begin
        if (check_en) begin
            logic e_fetch, e_mem, e_ld, e_st;
            e_fetch = (m_step == 0) || (m_step == 1);
            e_mem   = (m_step == 4) || (m_step == 5);
            e_ld    = (m_cls == 2'b01);
            e_st    = (m_cls == 2'b10);
            chk("im_enable", 128'(IM_enable), 128'(e_fetch));
            chk("im_read",   128'(IM_read),   128'(e_fetch));
            chk("im_write",  128'(IM_write),  128'd0);
            chk("ir_load",   128'(ir_load),   128'(m_step == 1));
            chk("alu_en",    128'(alu_en),    128'(m_step == 3));
            chk("dm_enable", 128'(DM_enable), 128'(e_mem && (e_ld || e_st)));
            chk("dm_read",   128'(DM_read),   128'(e_mem && e_ld));
            chk("dm_write",  128'(DM_write),  128'(e_mem && e_st));
            chk("dm_rw_excl", 128'(DM_read & DM_write), 128'd0);
            chk("mdr_load",  128'(mdr_load),  128'(m_step == 5 && e_ld));
            chk("reg_write", 128'(reg_write), 128'(m_step == 6 && (m_cls == 2'b00 || e_ld)));
            chk("busy",      128'(busy),      128'(m_step >= 0));
            chk("pc",        128'(PC),        128'(m_pc));
            chk("cycle_cnt", cycle_cnt,       m_cyc);
            chk("inst_cnt",  128'(inst_cnt),  128'(m_inst));
        end
    end

    logic [31:0] rw_mask;

    // Directed stimulus with hand-computed expectations.
    initial begin
        reset = 1'b1; run = 1'b0; halt_req = 1'b0;
        inst_class = 2'b00; br_taken = 1'b0; br_target = 10'd0;
        repeat (3) @(negedge clk);
        check_en = 1;
        chk("rst_pc",   128'(PC), 128'd0);
        chk("rst_busy", 128'(busy), 128'd0);
        chk("rst_cyc",  cycle_cnt, 128'd0);

        // Three ALU instructions from reset.
        #2 reset = 1'b0; run = 1'b1;
        rw_mask = '0;
        for (int k = 1; k <= 26; k++) begin
            @(negedge clk);
            if (reg_write) rw_mask[k] = 1'b1;
            if (k == 1)  chk("t1_first_fetch", 128'({busy, IM_read, PC}), 128'h800 | 128'h400);
            if (k == 9)  chk("t1_pc1", 128'(PC), 128'd1);
            if (k == 17) chk("t1_pc2", 128'(PC), 128'd2);
            if (k == 20) halt_req = 1'b1;
            if (k == 25) begin run = 1'b0; halt_req = 1'b0; end
        end
        chk("t1_pc3",    128'(PC), 128'd3);
        chk("t1_inst",   128'(inst_cnt), 128'd3);
        chk("t1_cyc",    cycle_cnt, 128'd24);
        chk("t1_rw_mask", 128'(rw_mask), 128'h0080_8080);

        // LOAD then STORE.
        inst_class = 2'b01; run = 1'b1;
        for (int k = 1; k <= 18; k++) begin
            @(negedge clk);
            if (k == 5)  chk("t2_ld_m0", 128'({DM_enable, DM_read, DM_write, mdr_load}), 128'b1100);
            if (k == 6)  chk("t2_ld_m1", 128'({DM_enable, DM_read, DM_write, mdr_load}), 128'b1101);
            if (k == 7)  chk("t2_ld_wb", 128'(reg_write), 128'd1);
            if (k == 9)  inst_class = 2'b10;
            if (k == 12) halt_req = 1'b1;
            if (k == 13) chk("t2_st_m0", 128'({DM_enable, DM_read, DM_write, mdr_load}), 128'b1010);
            if (k == 14) chk("t2_st_m1", 128'({DM_enable, DM_read, DM_write, mdr_load}), 128'b1010);
            if (k == 15) chk("t2_st_wb", 128'(reg_write), 128'd0);
            if (k == 17) begin run = 1'b0; halt_req = 1'b0; end
        end
        chk("t2_pc",   128'(PC), 128'd5);
        chk("t2_inst", 128'(inst_cnt), 128'd5);
        chk("t2_cyc",  cycle_cnt, 128'd40);

        // Branch to 3FF, wrap to 0, branch to 05A.
        inst_class = 2'b00; br_taken = 1'b1; br_target = 10'h3FF; run = 1'b1;
        for (int k = 1; k <= 26; k++) begin
            @(negedge clk);
            if (k == 9) begin
                chk("t3_pc_3ff", 128'(PC), 128'h3FF);
                br_taken = 1'b0;
            end
            if (k == 17) begin
                chk("t3_pc_wrap", 128'(PC), 128'd0);
                br_taken = 1'b1; br_target = 10'h05A;
            end
            if (k == 20) halt_req = 1'b1;
            if (k == 25) begin run = 1'b0; halt_req = 1'b0; br_taken = 1'b0; end
        end
        chk("t3_pc_05a", 128'(PC), 128'h05A);
        chk("t3_inst",   128'(inst_cnt), 128'd8);
        chk("t3_cyc",    cycle_cnt, 128'd64);

        // halt_req pulsed in DEC is ignored; held through PCU it stops the machine.
        run = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 3)  halt_req = 1'b1;
            if (k == 4)  halt_req = 1'b0;
            if (k == 9)  chk("t4_pulse_ignored", 128'({busy, IM_read}), 128'b11);
            if (k == 12) halt_req = 1'b1;
            if (k == 17) begin
                chk("t4_idle_busy", 128'(busy), 128'd0);
                chk("t4_idle_cyc",  cycle_cnt, 128'd80);
                run = 1'b0; halt_req = 1'b0;
            end
        end
        chk("t4_cyc_frozen", cycle_cnt, 128'd80);
        chk("t4_pc_kept",    128'(PC), 128'h05C);
        chk("t4_inst",       128'(inst_cnt), 128'd10);

        // Resume with a STORE, then reset in its M0.
        inst_class = 2'b10; run = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            if (k == 1) chk("t5_resume", 128'({busy, IM_read, PC}), 128'h800 | 128'h400 | 128'h05C);
            if (k == 5) chk("t5_m0_write", 128'(DM_write), 128'd1);
        end
        #2 reset = 1'b1;
        #1;
        chk("t5_rst_dmw",  128'({DM_enable, DM_write}), 128'd0);
        chk("t5_rst_pc",   128'(PC), 128'd0);
        chk("t5_rst_inst", 128'(inst_cnt), 128'd0);
        chk("t5_rst_cyc",  cycle_cnt, 128'd0);
        chk("t5_rst_busy", 128'(busy), 128'd0);
        @(negedge clk);

        // Reset release with run=1: fetch PC 0 on the first edge, halt after one instruction.
        #2 reset = 1'b0; run = 1'b1; inst_class = 2'b00; halt_req = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            if (k == 1) chk("t6_first_fetch", 128'({busy, IM_enable, PC}), 128'h800 | 128'h400);
            if (k == 9) begin
                chk("t6_halted", 128'({busy, PC}), 128'h001);
                chk("t6_inst",   128'(inst_cnt), 128'd1);
                chk("t6_cyc",    cycle_cnt, 128'd8);
                run = 1'b0; halt_req = 1'b0;
            end
        end
        repeat (2) @(negedge clk);

        check_en = 0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL have parameter MemSize, default 10, meaning PC / instruction-memory address width.
REQ-002 SHALL have parameter CntSize, default 128, meaning cycle_cnt width.
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port run  input  1  start/continue execution from IDLE.
REQ-006 SHALL have port halt_req  input  1  stop after current instruction.
REQ-007 SHALL have port inst_class  input  2  decoded class: 00 ALU, 01 LOAD, 10 STORE, 11 NOP.
REQ-008 SHALL have port br_taken  input  1  branch taken, valid in EX.
REQ-009 SHALL have port br_target  input  MemSize  branch target PC, valid in EX.
REQ-010 SHALL have port IM_enable, IM_read, IM_write  output  1 each  instruction-memory controls.
REQ-011 SHALL have port DM_enable, DM_read, DM_write  output  1 each  data-memory controls.
REQ-012 SHALL have port ir_load, alu_en, mdr_load, reg_write  output  1 each  datapath strobes.
REQ-013 SHALL have port PC  output  MemSize  current instruction address.
REQ-014 SHALL have port cycle_cnt  output  CntSize  active-cycle count.
REQ-015 SHALL have port inst_cnt  output  32  retired-instruction count.
REQ-016 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-017 SHALL implement states IDLE, F0, F1, DEC, EX, M0, M1, WB, PCU; every instruction takes exactly 8 cycles (F0..PCU), all classes.
REQ-018 SHALL transition IDLE->F0 when run=1, else remain in IDLE; F0->F1->DEC->EX->M0->M1->WB->PCU unconditionally.
REQ-019 SHALL, in PCU, go to IDLE if halt_req=1 or run=0, else go to F0.
REQ-020 SHALL decode all strobes as Moore outputs from the state register (no input-to-output combinational path).
REQ-021 F0 and F1: IM_enable=1, IM_read=1; F1 also ir_load=1.
REQ-022 DEC: latch inst_class into internal cls register.
REQ-023 EX: alu_en=1; latch br_taken and br_target.
REQ-024 M0 and M1: DM_enable=1 if cls is LOAD or STORE; DM_read=1 if LOAD; DM_write=1 if STORE; DM_read and DM_write never both high.
REQ-025 M1: mdr_load=1 if cls is LOAD.
REQ-026 WB: reg_write=1 if cls is ALU or LOAD; 0 for STORE and NOP.
REQ-027 PCU: PC <= latched br_target if latched br_taken, else PC+1 modulo 2^MemSize (2^MemSize-1 wraps to 0).
REQ-028 PCU: inst_cnt increments by 1, wrapping at 2^32.
REQ-029 IM_write SHALL be 0 in every state.
REQ-030 cycle_cnt SHALL increment by 1 every clock in which state != IDLE, wrapping at 2^CntSize; hold in IDLE.
REQ-031 halt_req and run SHALL be ignored outside IDLE and PCU; PC, inst_cnt and cycle_cnt SHALL hold in IDLE.

Reset
REQ-032 reset=1 SHALL, asynchronously and in any state, force state to IDLE, PC, cycle_cnt, inst_cnt, cls and latched branch fields to 0, and every strobe and busy to 0.
REQ-033 Reset mid-instruction (including M0/M1 with DM_write=1) SHALL drop DM_write immediately, with no PC update or count retirement for the aborted instruction.
REQ-034 After reset deasserts with run=1, the first F0 SHALL occur at the first rising edge, fetching PC=0.

Verification
REQ-035 Reset, run=1, inst_class=00 always, 3 instructions -> PC 0,1,2,3 at PCU exits; inst_cnt=3; cycle_cnt=24; reg_write high exactly in cycles 7, 15, 23.
REQ-036 LOAD then STORE -> first instr DM_read=1 in M0/M1 with mdr_load only in M1 and reg_write in WB; second DM_write=1 in M0/M1 and no reg_write.
REQ-037 PC=10'h3FF, ALU instruction -> PC=0 after PCU; br_taken=1, br_target=10'h05A in EX -> PC=10'h05A after PCU.
REQ-038 halt_req=1 pulsed in DEC only -> ignored, next F0 follows; halt_req held through PCU -> IDLE, busy=0, cycle_cnt frozen, run=1 resumes at F0 with PC preserved.
REQ-039 reset asserted mid-M0 of STORE -> same-cycle DM_write=0, PC=0, inst_cnt=0, cycle_cnt=0, state IDLE.
REQ-040 Every cycle of every test -> DM_read&DM_write=0, IM_write=0, all strobes 0 in IDLE.
